// File: rtl/alu_exec_pkg.sv
// Shared ALU op codes and execute-stage FSM encoding.
// Used by seq_alu_exec, alu_comb_core and the ALU control unit.
package alu_exec_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_LUI  = 4'b1010;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Combinational ADD/SUB/logic/compare/LUI datapath (shifts and unused codes give 0).
// Ports: op_i op code, a_i/b_i operands, res_o result.
module alu_comb_core
    import alu_exec_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [3:0]            op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] res_o
);

    logic lt_s;
    logic lt_u;

    assign lt_s = $signed(a_i) < $signed(b_i);
    assign lt_u = a_i < b_i;

    always_comb begin
        res_o = '0;
        case (op_i)
            ALU_ADD:  res_o = a_i + b_i;
            ALU_SUB:  res_o = a_i - b_i;
            ALU_AND:  res_o = a_i & b_i;
            ALU_OR:   res_o = a_i | b_i;
            ALU_XOR:  res_o = a_i ^ b_i;
            ALU_SLT:  res_o = {{(DATA_WIDTH-1){1'b0}}, lt_s};
            ALU_SLTU: res_o = {{(DATA_WIDTH-1){1'b0}}, lt_u};
            ALU_LUI:  res_o = b_i;
            default:  res_o = '0;
        endcase
    end

endmodule

// File: rtl/seq_alu_exec.sv
// Execute-stage ALU with start/done handshake; shifts iterate 1 bit per clock.
// Ports: clk, reset (sync, active-high), start_i, ALU_Operation_i, A_i, B_i,
//   busy_o (SHIFT state), done_o (1-cycle result-valid pulse), ALU_Result_o, Zero_o.
// Build option: FAST_SHIFT_EN selects a single-cycle barrel shifter (busy_o tied 0).
module seq_alu_exec
    import alu_exec_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [3:0]            ALU_Operation_i,
    input  logic [DATA_WIDTH-1:0] A_i,
    input  logic [DATA_WIDTH-1:0] B_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] ALU_Result_o,
    output logic                  Zero_o
);

    localparam int SW = $clog2(DATA_WIDTH);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic [DATA_WIDTH-1:0] core_res;
    logic [DATA_WIDTH-1:0] launch_res;
    logic [SW-1:0]         shamt;

    assign shamt = B_i[SW-1:0];

    alu_comb_core #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_core (
        .op_i (ALU_Operation_i),
        .a_i  (A_i),
        .b_i  (B_i),
        .res_o(core_res)
    );

`ifdef FAST_SHIFT_EN

    always_comb begin
        launch_res = core_res;
        case (ALU_Operation_i)
            ALU_SLL: launch_res = A_i << shamt;
            ALU_SRL: launch_res = A_i >> shamt;
            ALU_SRA: launch_res = $signed(A_i) >>> shamt;
            default: launch_res = core_res;
        endcase
    end

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_DONE;
                    res_d   = launch_res;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
        end
    end

    assign busy_o = 1'b0;

`else

    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] a_step;
    logic [SW-1:0]         cnt_q, cnt_d;
    logic [3:0]            op_q, op_d;

    // A zero-distance shift completes like any other single-cycle op.
    assign launch_res = is_shift(ALU_Operation_i) ? A_i : core_res;

    always_comb begin
        a_step = a_q;
        case (op_q)
            ALU_SLL: a_step = {a_q[DATA_WIDTH-2:0], 1'b0};
            ALU_SRL: a_step = {1'b0, a_q[DATA_WIDTH-1:1]};
            default: a_step = {a_q[DATA_WIDTH-1], a_q[DATA_WIDTH-1:1]};
        endcase
    end

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        a_d     = a_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (is_shift(ALU_Operation_i) && (shamt != '0)) begin
                        state_d = S_SHIFT;
                        a_d     = A_i;
                        cnt_d   = shamt;
                        op_d    = ALU_Operation_i;
                    end else begin
                        state_d = S_DONE;
                        res_d   = launch_res;
                    end
                end
            end
            S_SHIFT: begin
                a_d   = a_step;
                cnt_d = cnt_q - SW'(1);
                // The last bit is shifted on the edge that enters DONE.
                if (cnt_q == SW'(1)) begin
                    state_d = S_DONE;
                    res_d   = a_step;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            res_q   <= '0;
            a_q     <= '0;
            cnt_q   <= '0;
            op_q    <= ALU_ADD;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            a_q     <= a_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    assign busy_o = (state_q == S_SHIFT);

`endif

    assign done_o       = (state_q == S_DONE);
    assign ALU_Result_o = res_q;
    assign Zero_o       = (res_q == '0);

endmodule

// File: tb/tb_seq_alu_exec.sv
// Self-checking bench for seq_alu_exec: directed cases plus random ops
// against a behavioural model of results and completion latency.
module tb_seq_alu_exec;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic [3:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] res_o;
    logic        zero_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] last_exp;

    always #5 clk = ~clk;

    seq_alu_exec #(.DATA_WIDTH(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .start_i        (start_i),
        .ALU_Operation_i(op_i),
        .A_i            (a_i),
        .B_i            (b_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .ALU_Result_o   (res_o),
        .Zero_o         (zero_o)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return a << sh;
            4'd6:  return a >> sh;
            4'd7:  return $signed(a) >>> sh;
            4'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:  return (a < b) ? 32'd1 : 32'd0;
            4'd10: return b;
            default: return 32'd0;
        endcase
    endfunction

    // Edges after the start edge until done_o is visible.
    function automatic int latency(input logic [3:0] op, input logic [31:0] b);
`ifdef FAST_SHIFT_EN
        return 0;
`else
        if (op >= 4'd5 && op <= 4'd7) return int'(b % 32);
        return 0;
`endif
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit hold);
        int lat;
        logic [31:0] exp;
        exp = model(op, a, b);
        lat = latency(op, b);
        @(negedge clk);
        start_i = 1'b1;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        @(posedge clk);
        for (int j = 0; j <= lat; j++) begin
            @(negedge clk);
            if (!hold) start_i = 1'b0;
            // Captured operands must make later input changes irrelevant.
            a_i  = $urandom;
            b_i  = $urandom;
            op_i = 4'($urandom);
            if (j < lat) begin
                chk("busy", {31'd0, busy_o}, 32'd1);
                chk("done_early", {31'd0, done_o}, 32'd0);
            end else begin
                start_i = 1'b0;
                chk("done", {31'd0, done_o}, 32'd1);
                chk("busy_in_done", {31'd0, busy_o}, 32'd0);
                chk("result", res_o, exp);
                chk("zero", {31'd0, zero_o}, {31'd0, exp == 32'd0});
            end
            if (j < lat) @(posedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        chk("done_clear", {31'd0, done_o}, 32'd0);
        chk("result_hold", res_o, exp);
        last_exp = exp;
    endtask

    initial begin
        reset   = 1'b1;
        start_i = 1'b0;
        op_i    = 4'd0;
        a_i     = '0;
        b_i     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_result", res_o, 32'd0);
        chk("rst_zero", {31'd0, zero_o}, 32'd1);
        reset = 1'b0;

        run_op(4'd0, 32'd5, 32'd7, 1'b0);
        run_op(4'd1, 32'd3, 32'd3, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("sub_hold", res_o, 32'd0);
            chk("sub_zero", {31'd0, zero_o}, 32'd1);
            chk("idle_done", {31'd0, done_o}, 32'd0);
        end
        run_op(4'd7, 32'h8000_0000, 32'd4, 1'b0);
        run_op(4'd8, 32'hFFFF_FFFF, 32'd1, 1'b0);
        run_op(4'd9, 32'hFFFF_FFFF, 32'd1, 1'b0);
        run_op(4'd15, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        run_op(4'd5, 32'd1, 32'd31, 1'b1);
        run_op(4'd5, 32'h0000_1234, 32'd32, 1'b0);
        run_op(4'd10, 32'hDEAD_B000, 32'hABCD_E000, 1'b0);
        run_op(4'd0, 32'hFFFF_FFFF, 32'd1, 1'b0);

`ifndef FAST_SHIFT_EN
        // Reset in the 2nd SHIFT cycle of SRL by 8.
        run_op(4'd0, 32'd5, 32'd7, 1'b0);
        @(negedge clk);
        start_i = 1'b1;
        op_i    = 4'd6;
        a_i     = 32'hF0F0_F0F0;
        b_i     = 32'd8;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_busy", {31'd0, busy_o}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
        chk("mid_rst_done", {31'd0, done_o}, 32'd0);
        chk("mid_rst_result", res_o, 32'd0);
        chk("mid_rst_zero", {31'd0, zero_o}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("abandoned_done", {31'd0, done_o}, 32'd0);
        end
        run_op(4'd0, 32'd5, 32'd7, 1'b0);
`endif

        for (int i = 0; i < 150; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            if (i % 7 == 0) ra = 32'h8000_0000 | ra;
            if (i % 11 == 0) rb = ra;
            run_op(4'($urandom_range(0, 15)), ra, rb, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                chk("gap_hold", res_o, last_exp);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
